dmem_hs_model: RTL and testbench

- Parametrised byte-enable data memory for the pipelined MIPS core; the successor to the combinational, flat 4096-word data array with the always-ready write port.
- Adds a valid/ready request/response handshake with configurable read/write latency, a base address with range checking and an error response.
- Clears itself after reset with a hardware sweep rather than a one-cycle bulk clear.
- Sits between the core's M-stage data port, through a stall adapter, and the bench or SoC bus.

---
 rtl/dmem_hs_model.sv | 181 ++++++++++++++++++
 tb/tb_dmem_hs_model.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_hs_model.sv
// dmem_hs_model
// Byte-enable data memory with a valid/ready request/response handshake.
// One transaction may be outstanding at a time. A response appears LAT
// edges after the accept edge, counting the accept edge itself. Addresses
// are byte addresses relative to BASE_ADDR. Out-of-range requests do not
// touch the array and answer with resp_err=1 and zero data. After reset the
// array is swept to zero one word per cycle, and requests are refused until
// the sweep has finished.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   req_valid   request present
//   req_ready   request can be accepted this cycle (IDLE only)
//   req_addr    byte address; the low log2(BE_W) bits are ignored
//   req_byteen  byte write enables; all-zero means read
//   req_wdata   write data in natural lane positions
//   resp_valid  response present
//   resp_ready  consumer takes the response
//   resp_rdata  read data, or the merged word for writes
//   resp_err    the request was out of range
//   clear_busy  the post-reset clear sweep is in progress
module dmem_hs_model #(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LAT         = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W/8-1:0]   req_byteen,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  clear_busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // The wait counter only has to hold LAT-1.
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   clr_idx_reg;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [DATA_W-1:0]  resp_rdata_reg;
  logic               resp_err_reg;

  logic [DATA_W-1:0]  mem [DEPTH_WORDS];

  // Address decode. The subtraction is unsigned, so an address below
  // BASE_ADDR wraps to a huge offset; the explicit compare also rejects it.
  logic [31:0]        addr_off;
  logic [31:0]        word_off;
  logic [IDX_W-1:0]   idx;
  logic               in_range;
  logic               accept;
  logic               is_write;
  logic [DATA_W-1:0]  mem_rd;
  logic [DATA_W-1:0]  merged;

  assign addr_off = req_addr - BASE_ADDR;
  assign word_off = addr_off >> OFF_W;
  assign idx      = word_off[IDX_W-1:0];
  assign in_range = (req_addr >= BASE_ADDR) && (word_off < 32'(DEPTH_WORDS));
  assign accept   = (state_reg == S_IDLE) && req_valid;
  assign is_write = |req_byteen;

  // Read-modify-write: the current word is read combinationally so that a
  // partial write can be merged and returned on the same accept edge. With
  // no lanes enabled the merge is just the stored word, which serves reads.
  assign mem_rd = mem[idx];

  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
      assign merged[8*gi +: 8] = req_byteen[gi] ? req_wdata[8*gi +: 8]
                                                : mem_rd[8*gi +: 8];
    end
  endgenerate

  // Memory array: the clear sweep and accepted in-range writes. Nothing is
  // written on an edge where reset is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_reg == S_CLEAR) begin
        mem[clr_idx_reg] <= '0;
      end else if (accept && in_range && is_write) begin
        mem[idx] <= merged;
      end
    end
  end

  // State, sweep index and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_CLEAR;
      clr_idx_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == S_CLEAR) begin
        clr_idx_reg <= clr_idx_reg + IDX_W'(1);
      end
    end
  end

  // Next-state logic and handshake outputs. req_ready depends on state only.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    clear_busy = 1'b0;
    case (state_reg)
      S_CLEAR: begin
        clear_busy = 1'b1;
        if (clr_idx_reg == IDX_W'(DEPTH_WORDS - 1)) begin
          state_next = S_IDLE;
        end
      end
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LAT > 1) begin
            state_next = S_WAIT;
            cnt_next   = CNT_W'(LAT - 1);
          end else begin
            state_next = S_RESP;
          end
        end
      end
      S_WAIT: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_CLEAR;
      end
    endcase
  end

  // Response payload: captured on accept and held until the handshake.
  // resp_rdata keeps its value after the handshake; resp_err is cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
    end else if (accept) begin
      resp_rdata_reg <= in_range ? merged : '0;
      resp_err_reg   <= !in_range;
    end else if ((state_reg == S_RESP) && resp_ready) begin
      resp_err_reg <= 1'b0;
    end
  end

  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_dmem_hs_model.sv
module tb_dmem_hs_model;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [3:0]  req_byteen;
  logic [31:0] req_wdata;
  logic        resp_ready;

  // Index 0: BASE 0, LAT 2. Index 1: BASE 0x100, LAT 2. Index 2: BASE 0, LAT 1.
  logic        req_ready_a  [3];
  logic        resp_valid_a [3];
  logic [31:0] resp_rdata_a [3];
  logic        resp_err_a   [3];
  logic        clear_busy_a [3];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_hs_model #(.DATA_W(32), .DEPTH_WORDS(16), .BASE_ADDR(32'h0), .LAT(2)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_a[0]),
    .req_addr(req_addr), .req_byteen(req_byteen), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a[0]), .resp_ready(resp_ready), .resp_rdata(resp_rdata_a[0]),
    .resp_err(resp_err_a[0]), .clear_busy(clear_busy_a[0])
  );

  dmem_hs_model #(.DATA_W(32), .DEPTH_WORDS(16), .BASE_ADDR(32'h100), .LAT(2)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_a[1]),
    .req_addr(req_addr), .req_byteen(req_byteen), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a[1]), .resp_ready(resp_ready), .resp_rdata(resp_rdata_a[1]),
    .resp_err(resp_err_a[1]), .clear_busy(clear_busy_a[1])
  );

  dmem_hs_model #(.DATA_W(32), .DEPTH_WORDS(16), .BASE_ADDR(32'h0), .LAT(1)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_a[2]),
    .req_addr(req_addr), .req_byteen(req_byteen), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a[2]), .resp_ready(resp_ready), .resp_rdata(resp_rdata_a[2]),
    .resp_err(resp_err_a[2]), .clear_busy(clear_busy_a[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full transaction on DUT d. lat counts posedges from the accept edge
  // (inclusive) until resp_valid is observed.
  task automatic do_txn(input int d, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready_a[d] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready_wait", {63'd0, req_ready_a[d]}, 64'd1);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_byteen = be;
    req_wdata  = wd;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid  = 1'b0;
    req_byteen = 4'b0;
    while (!resp_valid_a[d] && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rd = resp_rdata_a[d];
    er = resp_err_a[d];
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    $display("txn dut%0d addr=%08h be=%b wdata=%08h -> rdata=%08h err=%b lat=%0d",
             d, addr, be, wd, rd, er, lat);
  endtask

  // Release reset at a negedge and count cycles until req_ready on DUT 0.
  task automatic release_and_count(input string tag);
    int cyc;
    logic busy_ok;
    cyc = 0;
    busy_ok = 1'b1;
    reset = 1'b0;
    while (!req_ready_a[0] && cyc < 100) begin
      if (!clear_busy_a[0]) busy_ok = 1'b0;
      cyc++;
      @(posedge clk);
      @(negedge clk);
    end
    chk({tag, "_clear_cycles"}, 64'(cyc), 64'd16);
    chk({tag, "_busy_during"}, {63'd0, busy_ok}, 64'd1);
    chk({tag, "_busy_after"}, {63'd0, clear_busy_a[0]}, 64'd0);
    $display("clear %s: req_ready after %0d cycles", tag, cyc);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          guard;
    logic        seen_valid;

    vecs[0]  = '{32'h0000_003C, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[1]  = '{32'h0000_0008, 4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{32'h0000_0008, 4'b0010, 32'h0000_1200, 32'hDEAD_12EF, 1'b0};
    vecs[3]  = '{32'h0000_0008, 4'b0000, 32'h0000_0000, 32'hDEAD_12EF, 1'b0};
    vecs[4]  = '{32'h0000_0040, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[5]  = '{32'h0000_0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[6]  = '{32'h0000_003C, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[7]  = '{32'h0000_000B, 4'b1111, 32'h1122_3344, 32'h1122_3344, 1'b0};
    vecs[8]  = '{32'h0000_0008, 4'b0000, 32'h0000_0000, 32'h1122_3344, 1'b0};
    vecs[9]  = '{32'h0000_0004, 4'b1000, 32'hAB00_0000, 32'hAB00_0000, 1'b0};
    vecs[10] = '{32'h0000_0005, 4'b0101, 32'h00CD_00EF, 32'hABCD_00EF, 1'b0};
    vecs[11] = '{32'h0000_0004, 4'b0000, 32'h0000_0000, 32'hABCD_00EF, 1'b0};
    vecs[12] = '{32'hFFFF_FFFC, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[13] = '{32'h0000_0010, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_byteen = 4'b0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready",  {63'd0, req_ready_a[0]},  64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid_a[0]}, 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata_a[0]),     64'd0);
    chk("rst_resp_err",   {63'd0, resp_err_a[0]},   64'd0);
    chk("rst_clear_busy", {63'd0, clear_busy_a[0]}, 64'd1);

    release_and_count("init");

    // Table-driven transactions on the LAT=2, BASE=0 instance.
    for (int i = 0; i < NV; i++) begin
      do_txn(0, vecs[i].addr, vecs[i].be, vecs[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d_err", i), {63'd0, er}, {63'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd2);
    end

    // Backpressure: response held for 5 cycles while a second request waits.
    @(negedge clk);
    guard = 0;
    while (!req_ready_a[0] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    req_valid  = 1'b1;
    req_addr   = 32'h14;
    req_byteen = 4'b1111;
    req_wdata  = 32'h55AA_55AA;
    @(posedge clk);
    @(negedge clk);
    req_byteen = 4'b0000;
    req_wdata  = 32'h0;
    guard = 0;
    while (!resp_valid_a[0] && guard < 20) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d", i),
          {29'd0, resp_valid_a[0], req_ready_a[0], resp_err_a[0], resp_rdata_a[0]},
          {29'd0, 1'b1, 1'b0, 1'b0, 32'h55AA_55AA});
      @(posedge clk);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp_idle_ready",  {63'd0, req_ready_a[0]},  64'd1);
    chk("bp_idle_valid",  {63'd0, resp_valid_a[0]}, 64'd0);
    chk("bp_rdata_holds", 64'(resp_rdata_a[0]),     64'h55AA_55AA);
    chk("bp_err_low",     {63'd0, resp_err_a[0]},   64'd0);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_second_accepted", {63'd0, req_ready_a[0]}, 64'd0);
    while (!resp_valid_a[0] && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("bp_second_rdata", 64'(resp_rdata_a[0]), 64'h55AA_55AA);
    chk("bp_second_lat",   64'(lat),             64'd2);
    $display("txn dut0 backpressured read addr=00000014 -> rdata=%08h lat=%0d",
             resp_rdata_a[0], lat);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;

    // Reset while a write is in WAIT: no response may ever appear.
    guard = 0;
    while (!req_ready_a[0] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    req_valid  = 1'b1;
    req_addr   = 32'h8;
    req_byteen = 4'b1111;
    req_wdata  = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_byteen = 4'b0;
    seen_valid = resp_valid_a[0];
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      seen_valid = seen_valid | resp_valid_a[0];
    end
    $display("reset asserted during WAIT");
    fork
      release_and_count("midrst");
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          seen_valid = seen_valid | resp_valid_a[0];
        end
      end
    join
    chk("midrst_no_resp", {63'd0, seen_valid}, 64'd0);
    do_txn(0, 32'h8, 4'b0000, 32'h0, rd, er, lat);
    chk("midrst_read_rdata", 64'(rd), 64'd0);
    chk("midrst_read_err",   {63'd0, er}, 64'd0);

    // BASE_ADDR = 0x100 instance.
    do_txn(1, 32'hFC, 4'b1111, 32'h1234_5678, rd, er, lat);
    chk("base_below_err",   {63'd0, er}, 64'd1);
    chk("base_below_rdata", 64'(rd),     64'd0);
    do_txn(1, 32'h13C, 4'b1111, 32'h0BAD_CAFE, rd, er, lat);
    chk("base_top_err",   {63'd0, er}, 64'd0);
    chk("base_top_rdata", 64'(rd),     64'h0BAD_CAFE);
    do_txn(1, 32'h140, 4'b0000, 32'h0, rd, er, lat);
    chk("base_above_err", {63'd0, er}, 64'd1);
    do_txn(1, 32'h100, 4'b0000, 32'h0, rd, er, lat);
    chk("base_word0_rdata", 64'(rd),     64'd0);
    chk("base_word0_err",   {63'd0, er}, 64'd0);

    // LAT = 1 instance with a misaligned write.
    do_txn(2, 32'hB, 4'b1111, 32'h1122_3344, rd, er, lat);
    chk("lat1_write_lat",   64'(lat), 64'd1);
    chk("lat1_write_rdata", 64'(rd),  64'h1122_3344);
    do_txn(2, 32'h8, 4'b0000, 32'h0, rd, er, lat);
    chk("lat1_read_lat",   64'(lat), 64'd1);
    chk("lat1_read_rdata", 64'(rd),  64'h1122_3344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
